ov7670_capture: RTL and testbench

Pixel-capture stage downstream of the OV7670 SCCB setup block. Once setup reports configuration complete, it samples the camera's parallel bus (PCLK, VSYNC, HREF, D[7:0]) in the system Clock domain and discards a programmable number of settling frames. It then assembles byte pairs into RGB565 pixels with X/Y coordinates and frame/line markers for the frame-buffer writer.

---
 rtl/ov7670_capture.sv | 213 +++++++++++++++++++++
 tb/tb_ov7670_capture.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture.sv
`timescale 1ns/1ps
// ov7670_capture
// Pixel-capture stage for an OV7670 camera running after the SCCB setup block.
// The asynchronous camera bus is brought into the Clock domain and evaluated
// only on detected PCLK rising edges. Complete settling frames are discarded
// after ConfigDone rises. Byte pairs are then assembled into RGB565 pixels
// with X/Y coordinates and frame/line markers.
//
// Ports:
//   Clock, Reset          system clock; synchronous active-high reset
//   ConfigDone            sensor configured (level); low forces WAIT_CFG
//   Enable                capture enable, sampled at frame start only
//   CamPclk/Vsync/Href    asynchronous camera timing signals
//   CamData[7:0]          camera data byte
//   PixelValid            one-cycle strobe; PixelData/X/Y valid (held until next)
//   PixelData[15:0]       RGB565, first byte of the pair in [15:8]
//   PixelX[9:0], PixelY[8:0] pixel coordinates
//   FrameStart/FrameEnd/LineEnd  one-cycle markers for delivered frames
//   LineLenErr/FrameLenErr       sticky length errors, cleared by Reset only
module ov7670_capture #(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int SKIP_FRAMES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ConfigDone,
  input  logic        Enable,
  input  logic        CamPclk,
  input  logic        CamVsync,
  input  logic        CamHref,
  input  logic [7:0]  CamData,
  output logic        PixelValid,
  output logic [15:0] PixelData,
  output logic [9:0]  PixelX,
  output logic [8:0]  PixelY,
  output logic        FrameStart,
  output logic        FrameEnd,
  output logic        LineEnd,
  output logic        LineLenErr,
  output logic        FrameLenErr
);

  localparam logic [11:0] LINE_BYTES = 12'(2 * IMG_WIDTH);
  localparam logic [9:0]  X_LIMIT    = 10'(IMG_WIDTH);
  localparam logic [8:0]  Y_TARGET   = 9'(IMG_HEIGHT);
  // With SKIP_FRAMES=0 this wraps to all-ones, but SKIP is never entered then.
  localparam logic [15:0] SKIP_LAST  = 16'(SKIP_FRAMES - 1);

  typedef enum logic [1:0] {WAIT_CFG, SKIP, WAIT_VS, ACTIVE} captureState;

  captureState state;

  // Synchronizer bundle: {pclk, vsync, href, data[7:0]}.
  logic [10:0] syncStage1;
  logic [10:0] syncStage2;
  logic        pclkStage3;

  logic        prevVsync;
  logic        prevHref;
  logic [15:0] skipCnt;
  logic [9:0]  xCnt;
  logic [8:0]  yCnt;
  logic [11:0] byteCnt;
  logic        bytePhase;
  logic [7:0]  hiByte;

  logic        pclkRise;
  logic        camVs;
  logic        camHref;
  logic [7:0]  camData;
  logic        vsRise;
  logic        vsFall;
  logic        hrefFall;
  logic [8:0]  yIncr;
  logic [8:0]  yAfterLine;

  assign pclkRise = syncStage2[10] & ~pclkStage3;
  assign camVs    = syncStage2[9];
  assign camHref  = syncStage2[8];
  assign camData  = syncStage2[7:0];

  // Edges are relative to the level captured at the previous PCLK edge.
  assign vsRise   = pclkRise &  camVs   & ~prevVsync;
  assign vsFall   = pclkRise & ~camVs   &  prevVsync;
  assign hrefFall = pclkRise & ~camHref &  prevHref;

  assign yIncr      = (yCnt == '1) ? yCnt : yCnt + 9'd1;
  // When HREF falls on the same PCLK edge as VSYNC rises, the line count
  // must already include that last line.
  assign yAfterLine = hrefFall ? yIncr : yCnt;

  // NOTE: clocked blocks use only non-blocking assignments so every register
  // sees pre-edge values; blocking assignments here would make results depend
  // on statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      syncStage1 <= '0;
      syncStage2 <= '0;
      pclkStage3 <= 1'b0;
    end else begin
      syncStage1 <= {CamPclk, CamVsync, CamHref, CamData};
      syncStage2 <= syncStage1;
      pclkStage3 <= syncStage2[10];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= WAIT_CFG;
      prevVsync   <= 1'b0;
      prevHref    <= 1'b0;
      skipCnt     <= '0;
      xCnt        <= '0;
      yCnt        <= '0;
      byteCnt     <= '0;
      bytePhase   <= 1'b0;
      hiByte      <= '0;
      PixelValid  <= 1'b0;
      PixelData   <= '0;
      PixelX      <= '0;
      PixelY      <= '0;
      FrameStart  <= 1'b0;
      FrameEnd    <= 1'b0;
      LineEnd     <= 1'b0;
      LineLenErr  <= 1'b0;
      FrameLenErr <= 1'b0;
    end else begin
      PixelValid <= 1'b0;
      FrameStart <= 1'b0;
      FrameEnd   <= 1'b0;
      LineEnd    <= 1'b0;

      if (pclkRise) begin
        prevVsync <= camVs;
        prevHref  <= camHref;
      end

      if (!ConfigDone) begin
        // Losing configuration abandons any frame silently.
        state     <= WAIT_CFG;
        skipCnt   <= '0;
        xCnt      <= '0;
        yCnt      <= '0;
        byteCnt   <= '0;
        bytePhase <= 1'b0;
      end else begin
        case (state)
          WAIT_CFG: begin
            skipCnt <= '0;
            state   <= (SKIP_FRAMES == 0) ? WAIT_VS : SKIP;
          end

          SKIP: begin
            if (vsRise) begin
              if (skipCnt == SKIP_LAST) state <= WAIT_VS;
              else                      skipCnt <= skipCnt + 16'd1;
            end
          end

          WAIT_VS: begin
            if (vsFall && Enable) begin
              state      <= ACTIVE;
              FrameStart <= 1'b1;
              xCnt       <= '0;
              yCnt       <= '0;
              byteCnt    <= '0;
              bytePhase  <= 1'b0;
            end
          end

          ACTIVE: begin
            if (pclkRise && camHref) begin
              if (byteCnt != '1) byteCnt <= byteCnt + 12'd1;
              if (!bytePhase) begin
                hiByte    <= camData;
                bytePhase <= 1'b1;
              end else begin
                bytePhase <= 1'b0;
                // xCnt saturates at X_LIMIT, so overlong lines drop extra pixels.
                if (xCnt != X_LIMIT) begin
                  PixelValid <= 1'b1;
                  PixelData  <= {hiByte, camData};
                  PixelX     <= xCnt;
                  PixelY     <= yCnt;
                  xCnt       <= xCnt + 10'd1;
                end
              end
            end

            if (hrefFall) begin
              LineEnd <= 1'b1;
              if (byteCnt != LINE_BYTES || bytePhase) LineLenErr <= 1'b1;
              yCnt      <= yIncr;
              xCnt      <= '0;
              byteCnt   <= '0;
              bytePhase <= 1'b0;
            end

            if (vsRise) begin
              FrameEnd <= 1'b1;
              if (yAfterLine != Y_TARGET) FrameLenErr <= 1'b1;
              state <= WAIT_VS;
            end
          end

          default: state <= WAIT_CFG;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
`timescale 1ns/1ps
// Directed bench for ov7670_capture with a 4x4 image and two skipped frames.
// Camera signals change 2 ns after a 10 ns grid, away from Clock edges.
module tb_ov7670_capture;

  localparam int W = 4;
  localparam int H = 4;

  logic        Clock;
  logic        Reset;
  logic        ConfigDone;
  logic        Enable;
  logic        CamPclk;
  logic        CamVsync;
  logic        CamHref;
  logic [7:0]  CamData;
  logic        PixelValid;
  logic [15:0] PixelData;
  logic [9:0]  PixelX;
  logic [8:0]  PixelY;
  logic        FrameStart;
  logic        FrameEnd;
  logic        LineEnd;
  logic        LineLenErr;
  logic        FrameLenErr;

  ov7670_capture #(
    .IMG_WIDTH(W),
    .IMG_HEIGHT(H),
    .SKIP_FRAMES(2)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .ConfigDone(ConfigDone),
    .Enable(Enable),
    .CamPclk(CamPclk),
    .CamVsync(CamVsync),
    .CamHref(CamHref),
    .CamData(CamData),
    .PixelValid(PixelValid),
    .PixelData(PixelData),
    .PixelX(PixelX),
    .PixelY(PixelY),
    .FrameStart(FrameStart),
    .FrameEnd(FrameEnd),
    .LineEnd(LineEnd),
    .LineLenErr(LineLenErr),
    .FrameLenErr(FrameLenErr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int testCount = 0;
  int failCount = 0;

  // Output log filled on the falling Clock edge.
  logic [15:0] logData [256];
  logic [9:0]  logX    [256];
  logic [8:0]  logY    [256];
  time         logTime [256];
  int pixN  = 0;
  int fsCnt = 0;
  int feCnt = 0;
  int leCnt = 0;

  always @(negedge Clock) begin
    if (PixelValid && pixN < 256) begin
      logData[pixN] <= PixelData;
      logX[pixN]    <= PixelX;
      logY[pixN]    <= PixelY;
      logTime[pixN] <= $time;
      pixN          <= pixN + 1;
    end
    if (FrameStart) fsCnt <= fsCnt + 1;
    if (FrameEnd)   feCnt <= feCnt + 1;
    if (LineEnd)    leCnt <= leCnt + 1;
  end

  time lastRise;
  time specRise;
  int  basePix, baseFs, baseFe, baseLe;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hiOf(input int x, input int y);
    if (x == 2 && y == 1) return 8'hA5;
    return {4'(y), 4'(x)};
  endfunction

  function automatic logic [7:0] loOf(input int x, input int y);
    if (x == 2 && y == 1) return 8'h3C;
    return ~{4'(y), 4'(x)};
  endfunction

  // One PCLK period: values change while PCLK is low, rise after 40 ns.
  task automatic camCycle(input logic vs, input logic hr, input logic [7:0] d);
    CamPclk  = 1'b0;
    CamVsync = vs;
    CamHref  = hr;
    CamData  = d;
    #40;
    CamPclk  = 1'b1;
    lastRise = $time;
    #40;
  endtask

  // VSYNC low, `lines` lines, then VSYNC high. oddLine gets 9 bytes;
  // ConfigDone is low during line cfgDropLine; Enable drops at enDropLine.
  task automatic sendFrame(input int lines, input int oddLine,
                           input int cfgDropLine, input int enDropLine);
    camCycle(1'b0, 1'b0, 8'h00);
    camCycle(1'b0, 1'b0, 8'h00);
    for (int y = 0; y < lines; y++) begin
      int nBytes;
      nBytes = (y == oddLine) ? 9 : 2 * W;
      if (y == cfgDropLine) ConfigDone = 1'b0;
      if (y == enDropLine)  Enable = 1'b0;
      for (int b = 0; b < nBytes; b++) begin
        if (b % 2 == 0) begin
          camCycle(1'b0, 1'b1, hiOf(b / 2, y));
        end else begin
          camCycle(1'b0, 1'b1, loOf(b / 2, y));
          if (b / 2 == 2 && y == 1) specRise = lastRise;
        end
      end
      camCycle(1'b0, 1'b0, 8'h00);
      camCycle(1'b0, 1'b0, 8'h00);
      if (y == cfgDropLine) ConfigDone = 1'b1;
    end
    camCycle(1'b1, 1'b0, 8'h00);
    camCycle(1'b1, 1'b0, 8'h00);
  endtask

  task automatic snap();
    basePix = pixN;
    baseFs  = fsCnt;
    baseFe  = feCnt;
    baseLe  = leCnt;
  endtask

  task automatic frameCounts(input string tag, input int expPix, input int expFs,
                             input int expLe, input int expFe);
    check({tag, " pixels"},     32'(pixN - basePix), 32'(expPix));
    check({tag, " FrameStart"}, 32'(fsCnt - baseFs), 32'(expFs));
    check({tag, " LineEnd"},    32'(leCnt - baseLe), 32'(expLe));
    check({tag, " FrameEnd"},   32'(feCnt - baseFe), 32'(expFe));
  endtask

  // Every delivered line carries W pixels at X=0..W-1.
  task automatic checkPixels(input string tag, input int lines);
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < W; x++) begin
        int idx;
        idx = (basePix + y * W + x) % 256;
        check($sformatf("%s y%0d x%0d data", tag, y, x), 32'(logData[idx]),
              32'({hiOf(x, y), loOf(x, y)}));
        check($sformatf("%s y%0d x%0d X", tag, y, x), 32'(logX[idx]), 32'(x));
        check($sformatf("%s y%0d x%0d Y", tag, y, x), 32'(logY[idx]), 32'(y));
      end
    end
  endtask

  initial begin
    Reset      = 1'b1;
    ConfigDone = 1'b0;
    Enable     = 1'b1;
    CamPclk    = 1'b0;
    CamVsync   = 1'b0;
    CamHref    = 1'b0;
    CamData    = 8'h00;
    lastRise   = 0;
    specRise   = 0;
    #2;
    #50;
    check("reset PixelValid",  32'(PixelValid),  32'd0);
    check("reset PixelData",   32'(PixelData),   32'd0);
    check("reset PixelX",      32'(PixelX),      32'd0);
    check("reset PixelY",      32'(PixelY),      32'd0);
    check("reset FrameStart",  32'(FrameStart),  32'd0);
    check("reset LineLenErr",  32'(LineLenErr),  32'd0);
    check("reset FrameLenErr", 32'(FrameLenErr), 32'd0);
    Reset = 1'b0;
    #30;
    ConfigDone = 1'b1;
    #20;

    // Two settling frames produce nothing.
    snap();
    sendFrame(H, -1, -1, -1);
    sendFrame(H, -1, -1, -1);
    frameCounts("skip", 0, 0, 0, 0);

    // First delivered frame.
    snap();
    sendFrame(H, -1, -1, -1);
    frameCounts("f3", W * H, 1, H, 1);
    checkPixels("f3", H);
    check("f3 A53C data", 32'(logData[(basePix + W + 2) % 256]), 32'h0000A53C);
    check("f3 latency ns", 32'(logTime[(basePix + W + 2) % 256] - specRise), 32'd28);
    check("f3 hold data", 32'(PixelData), 32'({hiOf(3, 3), loOf(3, 3)}));
    check("f3 hold X", 32'(PixelX), 32'd3);
    check("f3 hold Y", 32'(PixelY), 32'd3);
    check("f3 LineLenErr",  32'(LineLenErr),  32'd0);
    check("f3 FrameLenErr", 32'(FrameLenErr), 32'd0);

    // Odd-length line 1: 4 pixels, partial byte dropped, next line intact.
    snap();
    sendFrame(H, 1, -1, -1);
    frameCounts("f4", W * H, 1, H, 1);
    checkPixels("f4", H);
    check("f4 LineLenErr",  32'(LineLenErr),  32'd1);
    check("f4 FrameLenErr", 32'(FrameLenErr), 32'd0);

    // Short frame: FrameEnd still issued, FrameLenErr set.
    snap();
    sendFrame(H - 1, -1, -1, -1);
    frameCounts("f5", W * (H - 1), 1, H - 1, 1);
    check("f5 FrameLenErr", 32'(FrameLenErr), 32'd1);
    check("f5 LineLenErr sticky", 32'(LineLenErr), 32'd1);

    // ConfigDone low during line 1: frame abandoned without FrameEnd.
    snap();
    sendFrame(H, -1, 1, -1);
    frameCounts("f6", W, 1, 1, 0);
    checkPixels("f6", 1);

    // Skipping restarts: this frame is the second skipped one.
    snap();
    sendFrame(H, -1, -1, -1);
    frameCounts("f7", 0, 0, 0, 0);

    // Delivered; Enable falls at line 2 without aborting the frame.
    snap();
    sendFrame(H, -1, -1, 2);
    frameCounts("f8", W * H, 1, H, 1);
    checkPixels("f8", H);

    // Enable low at the VSYNC fall: frame ignored.
    snap();
    sendFrame(H, -1, -1, -1);
    frameCounts("f9", 0, 0, 0, 0);

    // Enable restored: next frame delivered.
    Enable = 1'b1;
    snap();
    sendFrame(H, -1, -1, -1);
    frameCounts("f10", W * H, 1, H, 1);
    checkPixels("f10", H);

    #100;
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
